// File: rtl/digit_serial_addsub.sv
// Digit-serial add/subtract unit.
// One DIGIT-wide carry chain is reused over WIDTH/DIGIT digits, and the carry is
// held between digits. The digit-0 add happens on the same edge that accepts
// start, so an operation takes exactly NDIG edges from start to done.
//
// Handshake: start is sampled only while idle (busy=0). The request is accepted on
// the rising edge where start=1 and the unit is idle. done pulses high for one
// cycle when sum/cout/ovf have been updated. start=1 in the done cycle is accepted.
// start while busy is ignored and is not queued.
`timescale 1ns/1ps
module digit_serial_addsub #(
    parameter int WIDTH = 32,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int NDIG = WIDTH / DIGIT;
    localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam logic [CW-1:0] LAST_DIG = CW'(NDIG - 1);

    // Reject parameter combinations that cannot be split into whole digits.
    generate
        if (WIDTH < 1 || DIGIT < 1 || DIGIT > WIDTH || (WIDTH % DIGIT) != 0) begin : g_bad_param
            $error("digit_serial_addsub: WIDTH=%0d must be a positive multiple of DIGIT=%0d",
                   WIDTH, DIGIT);
        end
    endgenerate

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t           state;
    state_t           state_nx;

    logic [CW-1:0]    cnt;       // index of the digit processed on the next RUN edge
    logic [WIDTH-1:0] a_reg;     // operand A, shifted right one digit per step
    logic [WIDTH-1:0] b_reg;     // operand B (inverted for subtract), shifted likewise
    logic [WIDTH-1:0] part;      // partial result, digits enter at the top
    logic             carry;     // carry held between digits

    logic             accept;    // start taken this cycle
    logic             step_en;   // a digit is processed on this edge
    logic             last;      // the digit processed on this edge is the final one
    logic [WIDTH-1:0] b_in;
    logic [DIGIT-1:0] da;
    logic [DIGIT-1:0] db;
    logic             dc;
    logic [DIGIT-1:0] ds;
    logic             dco;       // carry out of this digit
    logic             dcm;       // carry into the top bit of this digit
    logic [WIDTH-1:0] part_base;
    logic [WIDTH-1:0] part_nx;

    assign accept  = (state == IDLE) && start;
    assign step_en = accept || (state == RUN);
    assign b_in    = sub ? ~in2 : in2;

    // Select digit operands: live inputs on the accept edge, shifted registers afterwards.
    always_comb begin
        da   = a_reg[DIGIT-1:0];
        db   = b_reg[DIGIT-1:0];
        dc   = carry;
        last = (cnt == LAST_DIG);
        if (accept) begin
            da   = in1[DIGIT-1:0];
            db   = b_in[DIGIT-1:0];
            dc   = cin ^ sub;
            last = (NDIG == 1);
        end
    end

    // One digit of the carry chain plus the partial-result update.
    always_comb begin
        {dco, ds} = {1'b0, da} + {1'b0, db} + {{DIGIT{1'b0}}, dc};
        dcm       = ds[DIGIT-1] ^ da[DIGIT-1] ^ db[DIGIT-1];
        part_base = accept ? '0 : part;
        part_nx   = (part_base >> DIGIT) | (WIDTH'(ds) << (WIDTH - DIGIT));
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state logic: stay idle when a single digit finishes the whole operation.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (accept && !last) state_nx = RUN;
            RUN:     if (last) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Operand shift registers, held carry, digit counter and partial result.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_reg <= '0;
            b_reg <= '0;
            part  <= '0;
            carry <= 1'b0;
            cnt   <= '0;
        end else if (step_en) begin
            a_reg <= (accept ? in1 : a_reg) >> DIGIT;
            b_reg <= (accept ? b_in : b_reg) >> DIGIT;
            part  <= part_nx;
            carry <= dco;
            cnt   <= accept ? CW'(1) : cnt + CW'(1);
        end
    end

    // Result registers and done pulse; results change only when the final digit completes.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sum  <= '0;
            cout <= 1'b0;
            ovf  <= 1'b0;
            done <= 1'b0;
        end else begin
            done <= 1'b0;
            if (step_en && last) begin
                sum  <= part_nx;
                cout <= dco;
                ovf  <= dcm ^ dco;
                done <= 1'b1;
            end
        end
    end

    // busy mirrors the registered RUN state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            busy <= 1'b0;
        end else begin
            busy <= (state_nx == RUN);
        end
    end

endmodule
